mac_rx_parser: RTL
==================

# mac_rx_parser

Receive-side Ethernet MAC parser in the UDP stack clock domain. It consumes the per-frame GMII byte stream that the RGMII clock-crossing buffer delivers (`valid` contiguous per frame, at least one idle cycle between frames). It strips preamble/SFD, filters on destination MAC, extracts source MAC and EtherType, and strips the 4-byte FCS. It forwards the payload with a last marker and an optional CRC-error flag to the IP/ARP layer above.

## Interface
Parameters:
- `P_LOCAL_MAC` — default 48'h00_0A_35_01_FE_C0 — station MAC; frames are accepted if the destination equals this value or FF:FF:FF:FF:FF:FF.

Ports:
- `i_udp_stack_clk`  in  1  — the only clock.
- `i_rst`  in  1  — reset, asynchronous, active-high.
- `i_gmii_rx_data`  in  8  — frame byte, preamble included.
- `i_gmii_rx_valid`  in  1  — byte qualifier, high for the whole frame.
- `o_mac_data`  out  8  — payload byte.
- `o_mac_valid`  out  1  — payload qualifier.
- `o_mac_last`  out  1  — high with the final payload byte.
- `o_mac_type`  out  16  — EtherType, big-endian.
- `o_mac_src`  out  48  — source MAC, first byte received in bits [47:40].
- `o_crc_err`  out  1  — valid only with `o_mac_last`; 1 means FCS mismatch.
- `o_drop_cnt`  out  16  — saturating count of dropped frames.

## Operation
- Byte 0 of a burst is the first cycle where `valid` is high after being low. It is detected with a registered copy of `valid`.
- States:
  - `IDLE`: at burst start, byte 0x55 → `PRE`; any other byte → `DROP`.
  - `PRE`:
    - 0x55 → stay; more than 7 bytes of 0x55 → `DROP`.
    - 0xD5 → `HDR`.
    - any other byte → `DROP`.
  - `HDR`:
    - 14-byte counter: bytes 0-5 destination, 6-11 source, 12-13 type.
    - After byte 5, a destination that is neither `P_LOCAL_MAC` nor broadcast → `DROP`.
    - After byte 13 → `PAY`.
  - `PAY`:
    - Every byte enters a 4-byte delay line. Once 4 bytes are held, each new byte pushes the oldest to an output holding register.
    - The holding register is emitted on the next edge. `o_mac_last` = !`i_gmii_rx_valid` at that edge.
  - `DROP`: wait for `valid` low, then → `IDLE`.
- Any state: `valid` low in `PRE` or `HDR` (runt) → `IDLE`, frame counted as dropped, nothing emitted.
- Payload shorter than 1 byte (frame ends within 4 bytes of the type field): nothing emitted, counted as dropped.
- `o_drop_cnt` increments by 1 per dropped frame and saturates at 16'hFFFF.
- `o_mac_type` and `o_mac_src` latch at the end of `HDR`. They hold until the next frame's `HDR` completes.

## Timing
- Reset: state `IDLE`, delay line empty, all outputs 0 (`o_drop_cnt` = 0).
- Reset deasserted mid-burst: that burst is ignored. Hunting for a new frame starts only after a low `valid` cycle.
- Continuous frame: payload byte Dk sampled at edge t appears on `o_mac_data` at edge t+5.
- The last payload byte is emitted at the edge that samples `valid` low after FCS byte 3. `o_mac_last` and `o_crc_err` are valid in that cycle.
- `o_mac_valid` is contiguous within a frame and is never asserted outside `PAY` or the final flush cycle.
- No back-pressure: the consumer must accept one byte per cycle.

## Configuration
- `MAC_RX_CRC_CHECK_EN` defined:
  - CRC-32 runs over destination through FCS inclusive.
  - Reflected polynomial 0xEDB88320, register initialised to 0xFFFFFFFF at `HDR` entry.
  - `o_crc_err` = (register ≠ 0xDEBB20E3) at `o_mac_last`.
- Not defined: no CRC logic is built and `o_crc_err` is tied 0.

## Structure
- Shared package `eth_pkg`: `PREAMBLE_BYTE` (8'h55), `SFD_BYTE` (8'hD5), `BCAST_MAC`, `CRC32_RESIDUE` (32'hDEBB20E3), EtherType constants (0x0800, 0x0806), and the parser state enum.
- One sub-module `crc32_d8`: byte-wide reflected CRC-32 update with `init` and `en` inputs. It is instantiated only under `MAC_RX_CRC_CHECK_EN`.

## Test plan
- Good unicast frame: 7×0x55, 0xD5, dst = `P_LOCAL_MAC`, src 11:22:33:44:55:66, type 0x0800, 46 payload bytes 0x00..0x2D, correct FCS.
  - 46 outputs 0x00..0x2D; last byte 0x2D has `o_mac_last`=1 and `o_crc_err`=0.
  - `o_mac_type`=0x0800, `o_mac_src`=48'h112233445566; first byte appears 5 cycles after input.
- Same frame with FCS byte 0 flipped → identical payload output, `o_crc_err`=1 with last (macro on); `o_crc_err`=0 with macro off.
- Broadcast ARP frame (type 0x0806, 28-byte payload) → accepted, 28 bytes output. Frame to 02:00:00:00:00:01 → no output, `o_drop_cnt` 0→1.
- Bad SFD (0xD4) and runt frame (ends at header byte 9) → no output, `o_drop_cnt` +2; the next good frame is parsed normally.
- Back-to-back frames with a 1-cycle `valid` gap → both fully output. `o_mac_last` of frame 1 precedes the first byte of frame 2 with no overlap.
- `i_rst` pulsed in the middle of a payload → outputs 0 immediately. The remainder of that burst is ignored; the next frame is accepted.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the receive parser state encoding.
// Contains no logic. The CRC constants are used only when MAC_RX_CRC_CHECK_EN is defined.
package eth_pkg;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [15:0] ETYPE_IPV4    = 16'h0800;
    localparam logic [15:0] ETYPE_ARP     = 16'h0806;

    localparam logic [2:0]  PRE_MAX       = 3'd7;
    localparam logic [3:0]  HDR_DST_LAST  = 4'd5;
    localparam logic [3:0]  HDR_SRC_LAST  = 4'd11;
    localparam logic [3:0]  HDR_LAST      = 4'd13;
    localparam logic [2:0]  FCS_LEN       = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_PAY,
        ST_DROP
    } rx_state_e;
endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32. init_i reloads all-ones and has priority over en_i.
// en_i folds data_i into the register on the edge. The register is never inverted.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC32_POLY) : (crc_d >> 1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= '1;
        end else if (init_i) begin
            crc_q <= '1;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/mac_rx_parser.sv
// Ethernet RX parser: strips preamble/SFD/FCS, filters on dst MAC, and latches src/type; payload appears 5 edges after input, with no back-pressure.
// MAC_RX_CRC_CHECK_EN builds the FCS check; without it, o_crc_err is tied 0.
module mac_rx_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] P_LOCAL_MAC = 48'h00_0A_35_01_FE_C0
) (
    input  logic        i_udp_stack_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_gmii_rx_data,
    input  logic        i_gmii_rx_valid,
    output logic [7:0]  o_mac_data,
    output logic        o_mac_valid,
    output logic        o_mac_last,
    output logic [15:0] o_mac_type,
    output logic [47:0] o_mac_src,
    output logic        o_crc_err,
    output logic [15:0] o_drop_cnt
);
    rx_state_e       state_q;
    logic            valid_q;
    logic [2:0]      pre_cnt_q;
    logic [3:0]      hdr_cnt_q;
    logic [39:0]     dst_q;
    logic [47:0]     dst_d;
    logic [47:0]     src_q;
    logic [7:0]      type_hi_q;
    logic [3:0][7:0] dly_q;
    logic [2:0]      dly_cnt_q;
    logic [7:0]      hold_q;
    logic            hold_vld_q;
    logic [7:0]      mac_data_q;
    logic            mac_valid_q;
    logic            mac_last_q;
    logic            crc_err_q;
    logic [15:0]     mac_type_q;
    logic [47:0]     mac_src_q;
    logic [15:0]     drop_cnt_q;
    logic            burst_start;
    logic            dst_ok;
    logic            drop_d;
    logic            crc_bad;

    assign burst_start = i_gmii_rx_valid && !valid_q;
    assign dst_d       = {dst_q, i_gmii_rx_data};
    assign dst_ok      = (dst_d == P_LOCAL_MAC) || (dst_d == BCAST_MAC);

`ifdef MAC_RX_CRC_CHECK_EN
    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc_val;

    assign crc_init = (state_q == ST_PRE) && i_gmii_rx_valid && (i_gmii_rx_data == SFD_BYTE);
    assign crc_en   = i_gmii_rx_valid && ((state_q == ST_HDR) || (state_q == ST_PAY));

    crc32_d8 u_crc32 (
        .clk_i  (i_udp_stack_clk),
        .rst_i  (i_rst),
        .init_i (crc_init),
        .en_i   (crc_en),
        .data_i (i_gmii_rx_data),
        .crc_o  (crc_val)
    );

    assign crc_bad = (crc_val != CRC32_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    // A frame ending in PAY with nothing pushed to the holding register is shorter than its FCS.
    always_comb begin
        drop_d = 1'b0;
        case (state_q)
            ST_IDLE: drop_d = burst_start && (i_gmii_rx_data != PREAMBLE_BYTE);
            ST_PRE:  drop_d = !i_gmii_rx_valid ||
                              ((i_gmii_rx_data == PREAMBLE_BYTE) ? (pre_cnt_q == PRE_MAX)
                                                                 : (i_gmii_rx_data != SFD_BYTE));
            ST_HDR:  drop_d = !i_gmii_rx_valid || ((hdr_cnt_q == HDR_DST_LAST) && !dst_ok);
            ST_PAY:  drop_d = !i_gmii_rx_valid && !hold_vld_q;
            default: drop_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_udp_stack_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            // Treat reset as mid-burst so that a burst already running is ignored until valid drops.
            valid_q     <= 1'b1;
            pre_cnt_q   <= '0;
            hdr_cnt_q   <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            type_hi_q   <= '0;
            dly_q       <= '0;
            dly_cnt_q   <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            mac_data_q  <= '0;
            mac_valid_q <= 1'b0;
            mac_last_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            mac_type_q  <= '0;
            mac_src_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            valid_q     <= i_gmii_rx_valid;
            hold_vld_q  <= 1'b0;
            mac_valid_q <= hold_vld_q;
            mac_last_q  <= hold_vld_q && !i_gmii_rx_valid;
            crc_err_q   <= hold_vld_q && !i_gmii_rx_valid && crc_bad;
            if (hold_vld_q) begin
                mac_data_q <= hold_q;
            end
            if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (burst_start) begin
                        state_q   <= (i_gmii_rx_data == PREAMBLE_BYTE) ? ST_PRE : ST_DROP;
                        pre_cnt_q <= 3'd1;
                    end
                end
                ST_PRE: begin
                    if (!i_gmii_rx_valid) begin
                        state_q <= ST_IDLE;
                    end else if (i_gmii_rx_data == PREAMBLE_BYTE) begin
                        if (pre_cnt_q == PRE_MAX) begin
                            state_q <= ST_DROP;
                        end else begin
                            pre_cnt_q <= pre_cnt_q + 3'd1;
                        end
                    end else if (i_gmii_rx_data == SFD_BYTE) begin
                        state_q   <= ST_HDR;
                        hdr_cnt_q <= '0;
                    end else begin
                        state_q <= ST_DROP;
                    end
                end
                ST_HDR: begin
                    if (!i_gmii_rx_valid) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hdr_cnt_q <= hdr_cnt_q + 4'd1;
                        if (hdr_cnt_q <= HDR_DST_LAST) begin
                            dst_q <= dst_d[39:0];
                            if ((hdr_cnt_q == HDR_DST_LAST) && !dst_ok) begin
                                state_q <= ST_DROP;
                            end
                        end else if (hdr_cnt_q <= HDR_SRC_LAST) begin
                            src_q <= {src_q[39:0], i_gmii_rx_data};
                        end else if (hdr_cnt_q != HDR_LAST) begin
                            type_hi_q <= i_gmii_rx_data;
                        end else begin
                            mac_type_q <= {type_hi_q, i_gmii_rx_data};
                            mac_src_q  <= src_q;
                            dly_cnt_q  <= '0;
                            state_q    <= ST_PAY;
                        end
                    end
                end
                ST_PAY: begin
                    if (!i_gmii_rx_valid) begin
                        state_q <= ST_IDLE;
                    end else begin
                        // The last four bytes are the FCS, so only a byte four places back is known to be payload.
                        dly_q <= {dly_q[2:0], i_gmii_rx_data};
                        if (dly_cnt_q == FCS_LEN) begin
                            hold_q     <= dly_q[3];
                            hold_vld_q <= 1'b1;
                        end else begin
                            dly_cnt_q <= dly_cnt_q + 3'd1;
                        end
                    end
                end
                ST_DROP: begin
                    if (!i_gmii_rx_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_mac_data  = mac_data_q;
    assign o_mac_valid = mac_valid_q;
    assign o_mac_last  = mac_last_q;
    assign o_crc_err   = crc_err_q;
    assign o_mac_type  = mac_type_q;
    assign o_mac_src   = mac_src_q;
    assign o_drop_cnt  = drop_cnt_q;
endmodule
